// File: rtl/eb_skp_controller_if.sv
// Read-side bundle between the RX elastic buffer,
// the SKP controller and the downstream decoder.
interface eb_skp_controller_if #(
   parameter int DATA_WIDTH = 10,
   parameter int FILL_WIDTH = 5
);
   logic [FILL_WIDTH-1:0] fill_level;
   logic [DATA_WIDTH-1:0] rd_head;
   logic [DATA_WIDTH-1:0] rd_next;
   logic [1:0]            rd_adv;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  skp_added;
   logic                  skp_removed;
   logic                  underflow;
   logic                  overflow;

   modport master (
      output fill_level, rd_head, rd_next,
      input  rd_adv, data_out, data_valid,
      input  skp_added, skp_removed,
      input  underflow, overflow
   );

   modport slave (
      input  fill_level, rd_head, rd_next,
      output rd_adv, data_out, data_valid,
      output skp_added, skp_removed,
      output underflow, overflow
   );
endinterface

// File: rtl/eb_skp_controller.sv
// Elastic buffer read sequencer: keeps occupancy centred by
// inserting/deleting one SKP per SKP ordered set.
module eb_skp_controller #(
   parameter int DATA_WIDTH   = 10,
   parameter int BUFFER_DEPTH = 16,
   parameter int FILL_WIDTH   = 5,
   parameter int HIGH_WM      = 12,
   parameter int LOW_WM       = 4,
   parameter int START_LEVEL  = 8,
   parameter int MAX_SKP      = 5,
   parameter logic [DATA_WIDTH-1:0] COM_RDN = 10'h0FA,
   parameter logic [DATA_WIDTH-1:0] COM_RDP = 10'h305,
   parameter logic [DATA_WIDTH-1:0] SKP_RDN = 10'h0F4,
   parameter logic [DATA_WIDTH-1:0] SKP_RDP = 10'h30B
) (
   input  logic read_clk,
   input  logic rst_n,
   eb_skp_controller_if.slave bus
);

   localparam int CW = $clog2(MAX_SKP + 1);

   localparam logic [FILL_WIDTH-1:0] L_HIGH  = FILL_WIDTH'(HIGH_WM);
   localparam logic [FILL_WIDTH-1:0] L_LOW   = FILL_WIDTH'(LOW_WM);
   localparam logic [FILL_WIDTH-1:0] L_START = FILL_WIDTH'(START_LEVEL);
   localparam logic [FILL_WIDTH-1:0] L_DEPTH = FILL_WIDTH'(BUFFER_DEPTH);
   localparam logic [FILL_WIDTH-1:0] L_ONE   = FILL_WIDTH'(1);
   localparam logic [CW-1:0]         L_MAX   = CW'(MAX_SKP);
   localparam logic [CW-1:0]         L_INSLIM = CW'(MAX_SKP - 1);

   typedef enum logic [1:0] {
      S_FILL,
      S_RUN,
      S_OS
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_skp_cnt;
   logic                  r_adj_done;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_skp_added;
   logic                  r_skp_removed;
   logic                  r_underflow;
   logic                  r_overflow;

   logic          w_is_com;
   logic          w_is_skp;
   logic          w_nxt_skp;
   logic          w_empty;
   logic          w_full;
   logic          w_os_skp;
   logic          w_del;
   logic          w_ins;
   logic [CW-1:0] w_cnt_inc;
   logic [1:0]    w_adv;

   assign w_is_com  = (bus.rd_head == COM_RDN) || (bus.rd_head == COM_RDP);
   assign w_is_skp  = (bus.rd_head == SKP_RDN) || (bus.rd_head == SKP_RDP);
   assign w_nxt_skp = (bus.rd_next == SKP_RDN) || (bus.rd_next == SKP_RDP);
   assign w_empty   = (bus.fill_level == '0);
   assign w_full    = (bus.fill_level == L_DEPTH);
   assign w_cnt_inc = r_skp_cnt + CW'(1);

   assign w_os_skp = (r_state == S_OS) && w_is_skp && !w_empty;

   // rd_next is only trusted when at least two entries are present
   assign w_del = w_os_skp && !r_adj_done
                  && (bus.fill_level >= L_HIGH)
                  && (bus.fill_level > L_ONE)
                  && w_nxt_skp;

   assign w_ins = w_os_skp && !r_adj_done && !w_del
                  && (bus.fill_level <= L_LOW)
                  && (r_skp_cnt < L_INSLIM);

   always_comb begin
      w_adv = 2'd0;
      case (r_state)
         S_RUN, S_OS: begin
            if (w_empty)    w_adv = 2'd0;
            else if (w_del) w_adv = 2'd2;
            else if (w_ins) w_adv = 2'd0;
            else            w_adv = 2'd1;
         end
         default: w_adv = 2'd0;
      endcase
   end

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FILL;
         r_skp_cnt     <= '0;
         r_adj_done    <= 1'b0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_skp_added   <= 1'b0;
         r_skp_removed <= 1'b0;
         r_underflow   <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_skp_added   <= 1'b0;
         r_skp_removed <= 1'b0;
         r_underflow   <= 1'b0;
         if (w_full) r_overflow <= 1'b1;
         case (r_state)
            S_FILL: begin
               r_valid <= 1'b0;
               if (bus.fill_level >= L_START) r_state <= S_RUN;
            end
            S_RUN, S_OS: begin
               if (w_empty) begin
                  r_valid     <= 1'b0;
                  r_underflow <= 1'b1;
                  r_state     <= S_FILL;
               end else begin
                  r_data  <= bus.rd_head;
                  r_valid <= 1'b1;
                  if (w_os_skp) begin
                     r_skp_cnt <= w_cnt_inc;
                     if (w_del) begin
                        r_skp_removed <= 1'b1;
                        r_adj_done    <= 1'b1;
                     end
                     if (w_ins) begin
                        r_skp_added <= 1'b1;
                        r_adj_done  <= 1'b1;
                     end
                     if (w_cnt_inc == L_MAX) r_state <= S_RUN;
                  end else if (w_is_com) begin
                     r_state    <= S_OS;
                     r_skp_cnt  <= '0;
                     r_adj_done <= 1'b0;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign bus.rd_adv      = w_adv;
   assign bus.data_out    = r_data;
   assign bus.data_valid  = r_valid;
   assign bus.skp_added   = r_skp_added;
   assign bus.skp_removed = r_skp_removed;
   assign bus.underflow   = r_underflow;
   assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_eb_skp_controller.sv
// Bench for eb_skp_controller: a simple buffer model feeds
// symbol streams; a queue holds the expected output symbols.
module tb_eb_skp_controller;

   typedef struct packed {
      logic [9:0] d;
      logic       add;
      logic       rem;
   } exp_t;

   logic read_clk;
   logic rst_n;
   logic [9:0] mem [0:63];
   logic [5:0] rp;
   exp_t exp_q [$];
   int checks;
   int errors;

   eb_skp_controller_if #(.DATA_WIDTH(10), .FILL_WIDTH(5)) bus ();

   eb_skp_controller dut (
      .read_clk (read_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   initial read_clk = 1'b0;
   always #5 read_clk = ~read_clk;

   assign bus.rd_head = mem[rp];
   assign bus.rd_next = mem[rp + 6'd1];

   always @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) rp <= '0;
      else        rp <= rp + {4'd0, bus.rd_adv};
   end

   task automatic fill_mem();
      for (int i = 0; i < 64; i++) mem[i] = 10'h100 + 10'(i);
   endtask

   task automatic push(input logic [9:0] d, input logic a, input logic r);
      exp_t e;
      e.d = d; e.add = a; e.rem = r;
      exp_q.push_back(e);
   endtask

   // reset, apply fill, release; returns after the first edge
   task automatic start(input logic [4:0] f);
      rst_n = 1'b0;
      bus.fill_level = f;
      exp_q.delete();
      @(negedge read_clk);
      rst_n = 1'b1;
      @(negedge read_clk);
   endtask

   task automatic test_reset();
      fill_mem();
      rst_n = 1'b0;
      bus.fill_level = 5'd0;
      #1;
      checks++;
      if (bus.data_out !== 10'd0 || bus.data_valid !== 1'b0 ||
          bus.rd_adv !== 2'd0 || bus.skp_added !== 1'b0 ||
          bus.skp_removed !== 1'b0 || bus.underflow !== 1'b0 ||
          bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: out=%h v=%b adv=%0d a=%b r=%b u=%b o=%b want all 0",
                  bus.data_out, bus.data_valid, bus.rd_adv, bus.skp_added,
                  bus.skp_removed, bus.underflow, bus.overflow);
      end
   endtask

   task automatic test_startup();
      exp_t e;
      fill_mem();
      rst_n = 1'b0;
      bus.fill_level = 5'd0;
      exp_q.delete();
      push(mem[0], 1'b0, 1'b0);
      @(negedge read_clk);
      rst_n = 1'b1;
      for (int f = 0; f <= 8; f++) begin
         bus.fill_level = 5'(f);
         #1;
         checks++;
         if (bus.rd_adv !== 2'd0 || bus.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL startup_fill%0d: adv=%0d v=%b want adv=0 v=0",
                     f, bus.rd_adv, bus.data_valid);
         end
         @(negedge read_clk);
      end
      checks++;
      if (bus.rd_adv !== 2'd1 || bus.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL startup_first_adv: adv=%0d v=%b want adv=1 v=0",
                  bus.rd_adv, bus.data_valid);
      end
      @(negedge read_clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== e.d) begin
         errors++;
         $display("FAIL startup_first_out: v=%b out=%h want v=1 out=%h",
                  bus.data_valid, bus.data_out, e.d);
      end
   endtask

   task automatic test_delete();
      exp_t e;
      int n_skip;
      int n_hold;
      n_skip = 0; n_hold = 0;
      fill_mem();
      mem[0] = 10'h0FA; mem[1] = 10'h0F4;
      mem[2] = 10'h0F4; mem[3] = 10'h0F4;
      start(5'd13);
      push(10'h0FA, 1'b0, 1'b0);
      push(10'h0F4, 1'b0, 1'b1);
      push(10'h0F4, 1'b0, 1'b0);
      push(mem[4], 1'b0, 1'b0);
      push(mem[5], 1'b0, 1'b0);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         @(negedge read_clk);
         if (bus.rd_adv == 2'd2) n_skip++;
         if (bus.rd_adv == 2'd0) n_hold++;
         if (bus.data_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.data_out !== e.d || bus.skp_added !== e.add ||
                bus.skp_removed !== e.rem) begin
               errors++;
               $display("FAIL delete_out: got %h a=%b r=%b want %h a=%b r=%b",
                        bus.data_out, bus.skp_added, bus.skp_removed,
                        e.d, e.add, e.rem);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || n_skip != 1 || n_hold != 0) begin
         errors++;
         $display("FAIL delete_adv: left=%0d skips=%0d holds=%0d want 0/1/0",
                  exp_q.size(), n_skip, n_hold);
      end
   endtask

   task automatic test_insert();
      exp_t e;
      int n_skip;
      int n_hold;
      n_skip = 0; n_hold = 0;
      fill_mem();
      mem[0] = 10'h305; mem[1] = 10'h30B; mem[2] = 10'h111;
      start(5'd8);
      bus.fill_level = 5'd3;
      push(10'h305, 1'b0, 1'b0);
      push(10'h30B, 1'b1, 1'b0);
      push(10'h30B, 1'b0, 1'b0);
      push(10'h111, 1'b0, 1'b0);
      push(mem[3], 1'b0, 1'b0);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         @(negedge read_clk);
         if (bus.rd_adv == 2'd2) n_skip++;
         if (bus.rd_adv == 2'd0) n_hold++;
         if (bus.data_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.data_out !== e.d || bus.skp_added !== e.add ||
                bus.skp_removed !== e.rem) begin
               errors++;
               $display("FAIL insert_out: got %h a=%b r=%b want %h a=%b r=%b",
                        bus.data_out, bus.skp_added, bus.skp_removed,
                        e.d, e.add, e.rem);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || n_skip != 0 || n_hold != 1) begin
         errors++;
         $display("FAIL insert_adv: left=%0d skips=%0d holds=%0d want 0/0/1",
                  exp_q.size(), n_skip, n_hold);
      end
   endtask

   // pass 0: ordered set at mid fill; pass 1: bare SKPs at high fill
   task automatic test_no_adjust();
      exp_t e;
      int n_odd;
      for (int p = 0; p < 2; p++) begin
         n_odd = 0;
         fill_mem();
         if (p == 0) begin
            mem[0] = 10'h0FA; mem[1] = 10'h0F4; mem[2] = 10'h30B;
         end else begin
            mem[1] = 10'h0F4; mem[2] = 10'h30B;
         end
         start(p == 0 ? 5'd8 : 5'd13);
         for (int i = 0; i < 5; i++) push(mem[i], 1'b0, 1'b0);
         for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge read_clk);
            if (bus.rd_adv != 2'd1) n_odd++;
            if (bus.data_valid) begin
               e = exp_q.pop_front();
               checks++;
               if (bus.data_out !== e.d || bus.skp_added !== e.add ||
                   bus.skp_removed !== e.rem) begin
                  errors++;
                  $display("FAIL noadj%0d_out: got %h a=%b r=%b want %h a=%b r=%b",
                           p, bus.data_out, bus.skp_added, bus.skp_removed,
                           e.d, e.add, e.rem);
               end
            end
         end
         checks++;
         if (exp_q.size() != 0 || n_odd != 0) begin
            errors++;
            $display("FAIL noadj%0d_adv: left=%0d non-unit adv=%0d want 0/0",
                     p, exp_q.size(), n_odd);
         end
      end
   endtask

   task automatic test_single_skp();
      exp_t e;
      int n_odd;
      n_odd = 0;
      fill_mem();
      mem[0] = 10'h0FA; mem[1] = 10'h0F4; mem[2] = 10'h092;
      start(5'd14);
      push(10'h0FA, 1'b0, 1'b0);
      push(10'h0F4, 1'b0, 1'b0);
      push(10'h092, 1'b0, 1'b0);
      push(mem[3], 1'b0, 1'b0);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         @(negedge read_clk);
         if (bus.rd_adv != 2'd1) n_odd++;
         if (bus.data_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.data_out !== e.d || bus.skp_added !== e.add ||
                bus.skp_removed !== e.rem) begin
               errors++;
               $display("FAIL single_out: got %h a=%b r=%b want %h a=%b r=%b",
                        bus.data_out, bus.skp_added, bus.skp_removed,
                        e.d, e.add, e.rem);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || n_odd != 0) begin
         errors++;
         $display("FAIL single_adv: left=%0d non-unit adv=%0d want 0/0",
                  exp_q.size(), n_odd);
      end
   endtask

   task automatic test_underflow();
      fill_mem();
      start(5'd8);
      repeat (3) @(negedge read_clk);
      bus.fill_level = 5'd0;
      #1;
      checks++;
      if (bus.rd_adv !== 2'd0 || bus.underflow !== 1'b0) begin
         errors++;
         $display("FAIL uf_hold: adv=%0d u=%b want adv=0 u=0",
                  bus.rd_adv, bus.underflow);
      end
      @(negedge read_clk);
      checks++;
      if (bus.underflow !== 1'b1 || bus.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL uf_pulse: u=%b v=%b want u=1 v=0",
                  bus.underflow, bus.data_valid);
      end
      bus.fill_level = 5'd5;
      @(negedge read_clk);
      checks++;
      if (bus.underflow !== 1'b0 || bus.rd_adv !== 2'd0 ||
          bus.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL uf_refill: u=%b adv=%0d v=%b want u=0 adv=0 v=0",
                  bus.underflow, bus.rd_adv, bus.data_valid);
      end
   endtask

   task automatic test_overflow();
      fill_mem();
      start(5'd8);
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_idle: o=%b want 0", bus.overflow);
      end
      bus.fill_level = 5'd16;
      @(negedge read_clk);
      bus.fill_level = 5'd10;
      repeat (3) @(negedge read_clk);
      checks++;
      if (bus.overflow !== 1'b1 || bus.data_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: o=%b v=%b want o=1 v=1",
                  bus.overflow, bus.data_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: o=%b want 0", bus.overflow);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_set();
      fill_mem();
      mem[0] = 10'h0FA; mem[1] = 10'h0F4;
      mem[2] = 10'h0F4; mem[3] = 10'h0F4;
      start(5'd13);
      @(negedge read_clk);
      @(negedge read_clk);
      checks++;
      if (bus.skp_removed !== 1'b1) begin
         errors++;
         $display("FAIL midset_pre: r=%b want 1", bus.skp_removed);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.data_out !== 10'd0 || bus.data_valid !== 1'b0 ||
          bus.rd_adv !== 2'd0 || bus.skp_removed !== 1'b0 ||
          bus.skp_added !== 1'b0) begin
         errors++;
         $display("FAIL midset_rst: out=%h v=%b adv=%0d r=%b a=%b want all 0",
                  bus.data_out, bus.data_valid, bus.rd_adv,
                  bus.skp_removed, bus.skp_added);
      end
      @(negedge read_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.fill_level = 5'd0;
      test_reset();
      test_startup();
      test_delete();
      test_insert();
      test_no_adjust();
      test_single_skp();
      test_underflow();
      test_overflow();
      test_reset_mid_set();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
